// File: rtl/top_pkg.sv
// Shared constants for the day-of-year counter: seven-segment patterns and
// cumulative month-start offsets for common and leap years.
package top_pkg;

    typedef logic [6:0] doy_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam doy_t DOY_MIN = 7'd1;
    localparam doy_t DOY_MAX = 7'd99;

    // Index m holds the last day-of-year before month m+1 starts.
    localparam logic [3:0][6:0] MONTH_START_NL = {7'd90, 7'd59, 7'd31, 7'd0};
    localparam logic [3:0][6:0] MONTH_START_LY = {7'd91, 7'd60, 7'd31, 7'd0};

    function automatic logic [7:0] seg_of(input logic [3:0] value);
        logic [7:0] pat;
        case (value)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/top_seg7_dec.sv
// Active-low seven-segment decoder: one BCD digit plus a blank flag.
module seg7_dec
    import top_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : seg_of(value);
    end

endmodule

// File: rtl/top.sv
// Day-of-year step counter (1..99) with month/day display on six HEX digits.
// Define LEAP_YEAR_EN to use the 29-day February month map.
module top
    import top_pkg::*;
#(
    parameter int unsigned FAST_DIV = 1,
    parameter int unsigned SLOW_DIV = 2
) (
    input  logic       ADC_CLK_10,
    input  logic [1:0] KEY,
    input  logic [9:8] SW,
    output logic [7:0] HEX5,
    output logic [7:0] HEX4,
    output logic [7:0] HEX3,
    output logic [7:0] HEX2,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0,
    output logic [1:0] LEDR
);

`ifdef LEAP_YEAR_EN
    localparam logic [3:0][6:0] MONTH_START = MONTH_START_LY;
`else
    localparam logic [3:0][6:0] MONTH_START = MONTH_START_NL;
`endif

    localparam logic [23:0] FAST_MAX = 24'(FAST_DIV - 1);
    localparam logic [23:0] SLOW_MAX = 24'(SLOW_DIV - 1);

    logic        rst;
    logic        hold;
    logic [23:0] div_cnt;
    logic [23:0] div_max;
    logic        step;
    doy_t        count;
    logic [2:0]  month;
    doy_t        month_start;
    doy_t        day;
    logic [3:0]  doy_tens, doy_ones, day_tens, day_ones;
    logic [7:0]  seg5, seg4, seg3, seg2, seg1, seg0;

    assign rst  = ~KEY[0];
    assign hold = ~KEY[1];

    // Compare with >= so a switch to the faster rate mid-period steps at once
    // instead of running the divider around its full range.
    assign div_max = SW[9] ? SLOW_MAX : FAST_MAX;
    assign step    = ~hold & (div_cnt >= div_max);

    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (hold) begin
            div_cnt <= div_cnt;
        end else if (step) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 24'd1;
        end
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            count <= DOY_MIN;
        end else if (step) begin
            if (SW[8]) begin
                count <= (count == DOY_MIN) ? DOY_MAX : count - 7'd1;
            end else begin
                count <= (count == DOY_MAX) ? DOY_MIN : count + 7'd1;
            end
        end
    end

    always_comb begin
        month       = 3'd1;
        month_start = MONTH_START[0];
        for (int m = 1; m < 4; m++) begin
            if (count > MONTH_START[m]) begin
                month       = 3'(m + 1);
                month_start = MONTH_START[m];
            end
        end
        day = count - month_start;
    end

    assign doy_tens = 4'(count / 7'd10);
    assign doy_ones = 4'(count % 7'd10);
    assign day_tens = 4'(day / 7'd10);
    assign day_ones = 4'(day % 7'd10);

    seg7_dec u_hex5 (.value(doy_tens),     .blank(1'b0),             .seg(seg5));
    seg7_dec u_hex4 (.value(doy_ones),     .blank(1'b0),             .seg(seg4));
    seg7_dec u_hex3 (.value(4'd0),         .blank(1'b1),             .seg(seg3));
    seg7_dec u_hex2 (.value({1'b0, month}), .blank(1'b0),            .seg(seg2));
    seg7_dec u_hex1 (.value(day_tens),     .blank(day_tens == 4'd0), .seg(seg1));
    seg7_dec u_hex0 (.value(day_ones),     .blank(1'b0),             .seg(seg0));

    // Display and LEDs trail the counter by one cycle so they stay aligned.
    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            HEX5 <= SEG_0;
            HEX4 <= SEG_1;
            HEX3 <= SEG_BLANK;
            HEX2 <= SEG_1;
            HEX1 <= SEG_BLANK;
            HEX0 <= SEG_1;
            LEDR <= 2'b00;
        end else begin
            HEX5 <= seg5;
            HEX4 <= seg4;
            HEX3 <= seg3;
            HEX2 <= seg2;
            HEX1 <= seg1;
            HEX0 <= seg0;
            LEDR <= {count == DOY_MAX, step};
        end
    end

endmodule

// File: tb/tb_top.sv
// Bench for the day-of-year counter: directed milestones plus a randomized
// run against a calendar-level reference model.
module tb_top;

    logic       clk;
    logic [1:0] KEY;
    logic [9:8] SW;
    logic [7:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    logic [1:0] LEDR;

    int tests_run = 0;
    int tests_failed = 0;

    int m_n, m_elapsed, m_disp;
    bit m_led0, m_led1;

    logic [7:0] enc_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

`ifdef LEAP_YEAR_EN
    int month_len [4] = '{31, 29, 31, 30};
    localparam logic [49:0] D60 = {8'h82, 8'hC0, 8'hFF, 8'hA4, 8'hA4, 8'h90, 2'b01};
    localparam logic [49:0] D99 = {8'h90, 8'h90, 8'hFF, 8'h99, 8'hFF, 8'h80, 2'b11};
`else
    int month_len [4] = '{31, 28, 31, 30};
    localparam logic [49:0] D60 = {8'h82, 8'hC0, 8'hFF, 8'hB0, 8'hFF, 8'hF9, 2'b01};
    localparam logic [49:0] D99 = {8'h90, 8'h90, 8'hFF, 8'h99, 8'hFF, 8'h90, 2'b11};
`endif

    top #(.FAST_DIV(1), .SLOW_DIV(2)) dut (
        .ADC_CLK_10(clk),
        .KEY(KEY),
        .SW(SW),
        .HEX5(HEX5),
        .HEX4(HEX4),
        .HEX3(HEX3),
        .HEX2(HEX2),
        .HEX1(HEX1),
        .HEX0(HEX0),
        .LEDR(LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [49:0] expect_disp(input int n, input bit led1, input bit led0);
        int d, m;
        logic [7:0] h1;
        d = n;
        m = 1;
        while (d > month_len[m-1]) begin
            d -= month_len[m-1];
            m++;
        end
        h1 = (d / 10 == 0) ? 8'hFF : enc_tbl[d / 10];
        return {enc_tbl[n / 10], enc_tbl[n % 10], 8'hFF, enc_tbl[m], h1, enc_tbl[d % 10],
                led1, led0};
    endfunction

    task automatic check(input string tag, input logic [49:0] exp);
        logic [49:0] obs;
        obs = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, LEDR};
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; the model advances at the same edge.
    task automatic tick(input logic [1:0] key, input logic [1:0] sw);
        bit step;
        int div;
        KEY = key;
        SW  = sw;
        @(posedge clk);
        div = sw[1] ? 2 : 1;
        if (!key[0]) begin
            m_n = 1; m_elapsed = 0; m_disp = 1; m_led0 = 0; m_led1 = 0;
        end else begin
            m_disp = m_n;
            m_led1 = (m_n == 99);
            step   = key[1] && (m_elapsed + 1 >= div);
            m_led0 = step;
            if (step) begin
                if (sw[0]) m_n = (m_n == 1) ? 99 : m_n - 1;
                else       m_n = (m_n == 99) ? 1 : m_n + 1;
                m_elapsed = 0;
            end else if (key[1]) begin
                m_elapsed++;
            end
        end
        #1;
        check("model", expect_disp(m_disp, m_led1, m_led0));
    endtask

    localparam logic [49:0] D_RESET = {8'hC0, 8'hF9, 8'hFF, 8'hF9, 8'hFF, 8'hF9, 2'b00};
    localparam logic [49:0] D32     = {8'hB0, 8'hA4, 8'hFF, 8'hA4, 8'hFF, 8'hF9, 2'b01};
    localparam logic [49:0] D01_WR  = {8'hC0, 8'hF9, 8'hFF, 8'hF9, 8'hFF, 8'hF9, 2'b01};
    localparam logic [49:0] D02_SL  = {8'hC0, 8'hA4, 8'hFF, 8'hF9, 8'hFF, 8'hA4, 2'b00};

    initial begin
        KEY = 2'b10;
        SW  = 2'b00;
        m_n = 1; m_elapsed = 0; m_disp = 1; m_led0 = 0; m_led1 = 0;

        tick(2'b10, 2'b00);
        check("reset", D_RESET);

        for (int i = 0; i < 5; i++) tick(2'b01, 2'b00);
        check("hold", D_RESET);

        for (int i = 0; i < 32; i++) tick(2'b11, 2'b00);
        check("up_32", D32);
        for (int i = 0; i < 28; i++) tick(2'b11, 2'b00);
        check("up_60", D60);
        for (int i = 0; i < 39; i++) tick(2'b11, 2'b00);
        check("up_99", D99);
        tick(2'b11, 2'b00);
        check("wrap_up", D01_WR);

        tick(2'b10, 2'b01);
        tick(2'b11, 2'b01);
        tick(2'b11, 2'b01);
        check("down_99", D99);

        tick(2'b10, 2'b10);
        for (int i = 0; i < 3; i++) tick(2'b11, 2'b10);
        check("slow_rate", D02_SL);

        for (int i = 0; i < 600; i++) begin
            logic [1:0] k, s;
            k[0] = ($urandom_range(0, 59) != 0);
            k[1] = ($urandom_range(0, 4) != 0);
            s    = 2'($urandom_range(0, 3));
            tick(k, s);
        end

        tick(2'b10, 2'b00);
        check("reset_mid", D_RESET);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter FAST_DIV, default 1: clock cycles per count step when SW[9]=0; legal range 1..2^24.
REQ-002 Parameter SLOW_DIV, default 2: clock cycles per count step when SW[9]=1; legal range 1..2^24.
REQ-003 ADC_CLK_10  input  1  sole clock; all state updates on its rising edge.
REQ-004 KEY  input  2  active-low pushbuttons; KEY[0] is the reset button, and KEY[1] low holds the count.
REQ-005 Reset is synchronous and active-high: internal rst = ~KEY[0], sampled only on the rising edge of ADC_CLK_10.
REQ-006 SW  input  2 (bits 9:8)  SW[9] selects the rate (0=FAST_DIV, 1=SLOW_DIV); SW[8]=1 selects count-down, SW[8]=0 selects count-up.
REQ-007 HEX5  output  8  day-of-year tens digit.
REQ-008 HEX4  output  8  day-of-year ones digit.
REQ-009 HEX3  output  8  always blank (8'hFF).
REQ-010 HEX2  output  8  month digit.
REQ-011 HEX1  output  8  day-of-month tens digit, blanked when zero.
REQ-012 HEX0  output  8  day-of-month ones digit.
REQ-013 LEDR  output  2  LEDR[0] is the one-cycle step pulse; LEDR[1] is high while the count equals 99.

Function
REQ-014 All HEX outputs SHALL be active-low, with bit7 = decimal point held 1 and bits 6:0 = segments g..a.
REQ-015 Digit encodings SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
REQ-016 The day-of-year counter SHALL be 7 bits wide, with range 1..99.
REQ-017 A divider SHALL count 0..DIV-1 and emit a step when it reaches DIV-1; with DIV=1 a step occurs every cycle.
REQ-018 When the count advances on a step, the divider SHALL restart from 0.
REQ-019 While KEY[1]=0, the divider and the counter SHALL freeze, and LEDR[0] SHALL stay 0.
REQ-020 Count-up SHALL wrap 99 -> 1, and count-down SHALL wrap 1 -> 99; the value 0 SHALL never occur.
REQ-021 A change of SW[9] or SW[8] SHALL take effect on the next step; the divider SHALL NOT be reset by the change.
REQ-022 The non-leap month map SHALL be: 1-31 -> month 1 (day = n); 32-59 -> month 2 (n-31); 60-90 -> month 3 (n-59); 91-99 -> month 4 (n-90).
REQ-023 HEX outputs SHALL be registered, updating one cycle after the counter (total latency from step to display = 1 cycle).

Reset
REQ-024 While rst=1 on a clock edge: count=1, divider=0, LEDR=00, HEX5=C0, HEX4=F9, HEX3=FF, HEX2=F9, HEX1=FF, HEX0=F9 (displaying 01 / 1 / 1).
REQ-025 Reset SHALL take priority over hold and over a step occurring in the same cycle.
REQ-026 Reset asserted mid-count SHALL force the reset values on the next edge.

Configuration
REQ-027 The macro LEAP_YEAR_EN, when defined, SHALL give February 29 days: 32-60 -> month 2, 61-91 -> month 3 (n-60), 92-99 -> month 4 (n-91).
REQ-028 When LEAP_YEAR_EN is undefined, the map in REQ-022 SHALL apply.

Structure
REQ-029 A shared package SHALL hold the segment constants (SEG_0..SEG_9, SEG_BLANK) and the cumulative month-start constants for both year types.
REQ-030 A sub-module seg7_dec SHALL convert a 4-bit value plus a blank flag into an 8-bit pattern; it SHALL be instantiated six times, with HEX3 tied blank.
REQ-031 The divider, counter and month/day calculation SHALL stay in top.

Verification
REQ-032 Reset with defaults: KEY=10 for 1 edge, then KEY=11 -> the next display is 01 / 1 / 1, and HEX3=FF.
REQ-033 Count-up: SW=00, 31 steps from reset -> 32 / 2 / 1; 59 steps -> 60 / 3 / 1 (non-leap).
REQ-034 Wrap: count-up to 99 -> LEDR[1]=1 and display 99 / 4 / 9; the next step gives 01 / 1 / 1.
REQ-035 Hold and rate: KEY[1]=0 for 5 cycles -> the count is unchanged; SW[9]=1 -> one step every 2 cycles.
REQ-036 Count-down: SW[8]=1 from reset -> 99 on the first step, then 98.
REQ-037 LEAP_YEAR_EN defined: count 60 -> month 2 day 29, and 61 -> month 3 day 1.
